// File: rtl/piso_stuff_serializer.sv
// piso_stuff_serializer
//   Parallel-in/serial-out serializer for the USB transmit bit path. Words arrive on a
//   valid/ready handshake into a holding register, move to a shifter, and leave one bit per
//   shift_enable strobe. Optional bit stuffing inserts a 0 after STUFF_RUN consecutive 1s.
//
// Ports
//   clk           in   system clock, rising edge
//   nRST          in   asynchronous active-low reset
//   clear         in   synchronous abort, empties all state without a done pulse
//   shift_enable  in   bit-time strobe, consumes the bit on serial_out
//   data_in       in   parallel word (WIDTH bits)
//   data_valid    in   data_in is valid
//   data_ready    out  holding register empty
//   serial_out    out  current bit, idle value 1
//   stuff_bit     out  current serial_out bit is a stuffed 0
//   busy          out  holding register full, shifter non-empty or stuffed bit pending
//   done          out  one-cycle pulse after the final bit of a transmission is consumed
module piso_stuff_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          STUFF_EN  = 1'b1,
  parameter int unsigned STUFF_RUN = 6
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             clear,
  input  logic             shift_enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             stuff_bit,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = $clog2(STUFF_RUN + 1);

  localparam logic [CW-1:0] CntFull = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [RW-1:0] RunLast = RW'(STUFF_RUN - 1);

  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_run;
  logic             r_stuff_pend;
  logic             r_done;

  logic [WIDTH-1:0] w_hold_d;
  logic             w_hold_full_d;
  logic [WIDTH-1:0] w_shift_d;
  logic [CW-1:0]    w_cnt_d;
  logic [RW-1:0]    w_run_d;
  logic             w_stuff_pend_d;
  logic             w_done_d;

  logic w_head;
  logic w_accept;
  logic w_consume;
  logic w_load;
  logic w_idle_d;

  assign w_head    = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign w_accept  = data_valid && !r_hold_full;
  assign w_consume = shift_enable && ((r_cnt != '0) || r_stuff_pend);

  // Load into an empty shifter, or reload on the edge that consumes the last data bit so
  // the next word follows without an idle bit.
  assign w_load = r_hold_full &&
                  ((r_cnt == '0) || (w_consume && !r_stuff_pend && (r_cnt == CntOne)));

  always_comb begin
    w_hold_d       = r_hold;
    w_hold_full_d  = r_hold_full;
    w_shift_d      = r_shift;
    w_cnt_d        = r_cnt;
    w_run_d        = r_run;
    w_stuff_pend_d = r_stuff_pend;
    w_done_d       = 1'b0;

    if (clear) begin
      w_hold_full_d  = 1'b0;
      w_cnt_d        = '0;
      w_run_d        = '0;
      w_stuff_pend_d = 1'b0;
    end else begin
      if (w_consume) begin
        if (r_stuff_pend) begin
          // Stuffed 0 goes out; the shifter holds still.
          w_stuff_pend_d = 1'b0;
          w_run_d        = '0;
        end else begin
          w_shift_d = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
          w_cnt_d   = r_cnt - CntOne;
          if (w_head) begin
            if (STUFF_EN) begin
              if (r_run == RunLast) begin
                w_stuff_pend_d = 1'b1;
                w_run_d        = '0;
              end else begin
                w_run_d = r_run + RW'(1);
              end
            end
          end else begin
            w_run_d = '0;
          end
        end
      end

      if (w_load) begin
        w_shift_d     = r_hold;
        w_cnt_d       = CntFull;
        w_hold_full_d = 1'b0;
      end

      // Accept only happens with an empty holding register, so it never collides with a load.
      if (w_accept) begin
        w_hold_d      = data_in;
        w_hold_full_d = 1'b1;
      end

      if (w_idle_d) begin
        w_run_d = '0;
        if (w_consume) begin
          w_done_d = 1'b1;
        end
      end
    end
  end

  assign w_idle_d = (w_cnt_d == '0) && !w_stuff_pend_d && !w_hold_full_d;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_run        <= '0;
      r_stuff_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_hold       <= w_hold_d;
      r_hold_full  <= w_hold_full_d;
      r_shift      <= w_shift_d;
      r_cnt        <= w_cnt_d;
      r_run        <= w_run_d;
      r_stuff_pend <= w_stuff_pend_d;
      r_done       <= w_done_d;
    end
  end

  always_comb begin
    if (r_stuff_pend) begin
      serial_out = 1'b0;
    end else if (r_cnt != '0) begin
      serial_out = w_head;
    end else begin
      serial_out = 1'b1;
    end
  end

  assign stuff_bit  = STUFF_EN && r_stuff_pend;
  assign busy       = r_hold_full || (r_cnt != '0) || r_stuff_pend;
  assign data_ready = !r_hold_full;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_stuff_serializer.sv
// Bench for piso_stuff_serializer. Three instances share the inputs:
//   0: LSB first, stuffing on;  1: MSB first, stuffing on;  2: LSB first, stuffing off.
// The reference keeps, per instance, a queue of the bits still to be emitted (data bits and
// stuffed zeros), expanded from each word when it enters the shifter.
module tb_piso_stuff_serializer;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       clear = 1'b0;
  logic       shift_enable = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic so  [NI];
  logic sb  [NI];
  logic rdy [NI];
  logic bsy [NI];
  logic dn  [NI];

  always #5 clk = ~clk;

  piso_stuff_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .STUFF_EN(1'b1), .STUFF_RUN(6)) u_lsb (
    .clk(clk), .nRST(nRST), .clear(clear), .shift_enable(shift_enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy[0]), .serial_out(so[0]), .stuff_bit(sb[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  piso_stuff_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .STUFF_EN(1'b1), .STUFF_RUN(6)) u_msb (
    .clk(clk), .nRST(nRST), .clear(clear), .shift_enable(shift_enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy[1]), .serial_out(so[1]), .stuff_bit(sb[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  piso_stuff_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .STUFF_EN(1'b0), .STUFF_RUN(6)) u_nos (
    .clk(clk), .nRST(nRST), .clear(clear), .shift_enable(shift_enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(rdy[2]), .serial_out(so[2]), .stuff_bit(sb[2]),
    .busy(bsy[2]), .done(dn[2])
  );

  // Reference state. Queue entries are {stuffed, bit}.
  logic [1:0] m_q   [NI][32];
  int         m_len [NI];
  logic [7:0] m_hold[NI];
  bit         m_hf  [NI];
  int         m_run [NI];
  bit         m_done[NI];

  logic [1:0] act_log[NI][32];
  logic [1:0] mdl_log[NI][32];
  int         act_n  [NI];
  int         mdl_n  [NI];
  int         done_cnt[NI];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit lsbf(int k);
    return (k != 1);
  endfunction

  function automatic bit sen(int k);
    return (k != 2);
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset_one(int k);
    m_len[k]  = 0;
    m_hf[k]   = 1'b0;
    m_run[k]  = 0;
    m_done[k] = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) model_reset_one(k);
  endtask

  task automatic model_push(int k, logic [1:0] e);
    if (m_len[k] < 32) begin
      m_q[k][m_len[k]] = e;
      m_len[k]++;
    end
  endtask

  // Expand a word into its emitted bit sequence, continuing the ones run of the transmission.
  task automatic model_load(int k, logic [7:0] w);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = lsbf(k) ? w[i] : w[7-i];
      model_push(k, {1'b0, b});
      if (b) begin
        if (sen(k)) begin
          m_run[k]++;
          if (m_run[k] == 6) begin
            model_push(k, 2'b10);
            m_run[k] = 0;
          end
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic model_pop(int k);
    if (mdl_n[k] < 32) begin
      mdl_log[k][mdl_n[k]] = m_q[k][0];
      mdl_n[k]++;
    end
    for (int j = 0; j < m_len[k] - 1; j++) m_q[k][j] = m_q[k][j+1];
    m_len[k]--;
  endtask

  task automatic model_update();
    bit hf_pre;
    bit consumed;
    int left;
    for (int k = 0; k < NI; k++) begin
      hf_pre = m_hf[k];
      if (!nRST || clear) begin
        model_reset_one(k);
      end else begin
        consumed = shift_enable && (m_len[k] > 0);
        if (consumed) model_pop(k);
        left = 0;
        for (int j = 0; j < m_len[k]; j++) if (!m_q[k][j][1]) left++;
        if (hf_pre && left == 0) begin
          model_load(k, m_hold[k]);
          m_hf[k] = 1'b0;
        end
        if (data_valid && !hf_pre) begin
          m_hold[k] = data_in;
          m_hf[k]   = 1'b1;
        end
        m_done[k] = consumed && (m_len[k] == 0) && !m_hf[k];
        if (m_len[k] == 0 && !m_hf[k]) m_run[k] = 0;
      end
    end
  endtask

  // One clock: log the bits the DUTs present for consumption, step the reference on the edge,
  // then return just after the edge so inputs change away from it.
  task automatic tick();
    for (int k = 0; k < NI; k++) begin
      if (shift_enable && nRST && !clear && m_len[k] > 0 && act_n[k] < 32) begin
        act_log[k][act_n[k]] = {sb[k], so[k]};
        act_n[k]++;
      end
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Compare every output of every instance against the reference on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      check("serial_out", k, 32'(so[k]), 32'((m_len[k] > 0) ? m_q[k][0][0] : 1'b1));
      check("stuff_bit", k, 32'(sb[k]), 32'((m_len[k] > 0) && m_q[k][0][1]));
      check("busy", k, 32'(bsy[k]), 32'(m_hf[k] || (m_len[k] > 0)));
      check("data_ready", k, 32'(rdy[k]), 32'(!m_hf[k]));
      check("done", k, 32'(dn[k]), 32'(m_done[k]));
      if (dn[k] === 1'b1) done_cnt[k]++;
    end
  end

  task automatic clear_logs();
    for (int k = 0; k < NI; k++) begin
      act_n[k] = 0;
      mdl_n[k] = 0;
    end
  endtask

  // Pin both the DUT and the reference to a hand-written stream: '0', '1', 's' = stuffed 0.
  task automatic check_stream(string name, int k, string exp);
    logic [1:0] e;
    byte        c;
    check({name, " length"}, k, 32'(act_n[k]), 32'(exp.len()));
    check({name, " model length"}, k, 32'(mdl_n[k]), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < 32; i++) begin
      c = exp.getc(i);
      e = (c == "s") ? 2'b10 : ((c == "1") ? 2'b01 : 2'b00);
      if (i < act_n[k]) check({name, " bit"}, k, 32'(act_log[k][i]), 32'(e));
      if (i < mdl_n[k]) check({name, " model bit"}, k, 32'(mdl_log[k][i]), 32'(e));
    end
  endtask

  task automatic run_stream(string name, logic [7:0] w0, bit two, logic [7:0] w1,
                            string e0, string e1, string e2);
    int d0 [NI];
    clear_logs();
    for (int k = 0; k < NI; k++) d0[k] = done_cnt[k];
    shift_enable = 1'b1;
    data_valid   = 1'b1;
    data_in      = w0;
    tick();
    data_valid = 1'b0;
    tick();
    if (two) begin
      data_valid = 1'b1;
      data_in    = w1;
      tick();
      data_valid = 1'b0;
    end
    repeat (24) tick();
    shift_enable = 1'b0;
    repeat (2) tick();
    check_stream(name, 0, e0);
    check_stream(name, 1, e1);
    check_stream(name, 2, e2);
    for (int k = 0; k < NI; k++) check({name, " done pulses"}, k, 32'(done_cnt[k] - d0[k]), 1);
  endtask

  // Load 0xB7 into the shifter, hold a second word, and consume three bits.
  task automatic setup_abort(logic [7:0] w1);
    clear_logs();
    shift_enable = 1'b0;
    data_valid   = 1'b1;
    data_in      = 8'hB7;
    tick();
    data_valid = 1'b0;
    tick();
    data_valid = 1'b1;
    data_in    = w1;
    tick();
    data_valid   = 1'b0;
    shift_enable = 1'b1;
    repeat (3) tick();
    shift_enable = 1'b0;
  endtask

  function automatic logic [7:0] pick_word();
    case ($urandom % 6)
      0:       return 8'hFF;
      1:       return 8'h7F;
      2:       return 8'hFE;
      3:       return 8'h3F;
      4:       return 8'hFC;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int d0 [NI];
    model_reset();
    clear_logs();
    for (int k = 0; k < NI; k++) done_cnt[k] = 0;

    repeat (2) tick();
    nRST = 1'b1;
    for (int k = 0; k < NI; k++) begin
      check("reset data_ready", k, 32'(rdy[k]), 1);
      check("reset serial_out", k, 32'(so[k]), 1);
      check("reset busy", k, 32'(bsy[k]), 0);
      check("reset done", k, 32'(dn[k]), 0);
    end

    // Strobes while idle must change nothing.
    repeat (16) begin
      shift_enable = 1'($urandom % 2);
      tick();
    end
    shift_enable = 1'b0;
    tick();
    check("idle serial_out", 0, 32'(so[0]), 1);
    check("idle busy", 0, 32'(bsy[0]), 0);
    check("idle done count", 0, 32'(done_cnt[0]), 0);

    run_stream("b7", 8'hB7, 1'b0, 8'h00, "11101101", "10110111", "11101101");
    run_stream("ff01", 8'hFF, 1'b1, 8'h01,
               "111111s1110000000", "111111s1100000001", "1111111110000000");
    run_stream("fc", 8'hFC, 1'b0, 8'h00, "00111111s", "111111s00", "00111111");

    // Synchronous abort with a word held.
    setup_abort(8'h55);
    for (int k = 0; k < NI; k++) d0[k] = done_cnt[k];
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check("clear busy", k, 32'(bsy[k]), 0);
      check("clear data_ready", k, 32'(rdy[k]), 1);
      check("clear serial_out", k, 32'(so[k]), 1);
      check("clear bits before abort", k, 32'(act_n[k]), 3);
    end
    repeat (4) tick();
    for (int k = 0; k < NI; k++) check("clear no done", k, 32'(done_cnt[k] - d0[k]), 0);

    // Asynchronous reset mid-word.
    setup_abort(8'hA5);
    for (int k = 0; k < NI; k++) d0[k] = done_cnt[k];
    shift_enable = 1'b1;
    nRST = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      check("async reset serial_out", k, 32'(so[k]), 1);
      check("async reset stuff_bit", k, 32'(sb[k]), 0);
      check("async reset busy", k, 32'(bsy[k]), 0);
      check("async reset data_ready", k, 32'(rdy[k]), 1);
      check("async reset done", k, 32'(dn[k]), 0);
    end
    shift_enable = 1'b0;
    repeat (2) tick();
    nRST = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < NI; k++) check("async reset no done", k, 32'(done_cnt[k] - d0[k]), 0);

    // Randomised traffic against the reference.
    repeat (3000) begin
      data_valid   = ($urandom % 100) < 40;
      data_in      = pick_word();
      shift_enable = ($urandom % 100) < 60;
      clear        = ($urandom % 200) == 0;
      if (($urandom % 1000) == 0) begin
        nRST = 1'b0;
        #1;
        model_reset();
        tick();
        nRST = 1'b1;
      end
      tick();
    end
    data_valid   = 1'b0;
    clear        = 1'b0;
    shift_enable = 1'b1;
    repeat (40) tick();
    for (int k = 0; k < NI; k++) check("drained busy", k, 32'(bsy[k]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
